// File: rtl/io_run_monitor.sv
// Synthesizable I/O-write checker and halt watchdog for the CPU bus.
// Compares checked I/O writes against a golden value and ends a run on the halt idiom or a timeout.
module io_run_monitor #(
    parameter int                DATA_W        = 8,
    parameter int                ADDR_W        = 4,
    parameter int                MAX_CYCLES    = 2000,
    parameter int                SETTLE_CYCLES = 2,
    parameter int                CNT_W         = 32,
    parameter int                ERR_W         = 16,
    parameter logic [DATA_W-1:0] HALT_OPCODE   = DATA_W'(8'h20),
    parameter logic [DATA_W-1:0] HALT_OPERAND  = DATA_W'(8'hFE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   io_we,
    input  logic                   io_oe,
    input  logic [ADDR_W-1:0]      io_addr,
    input  logic [DATA_W-1:0]      io_data,
    input  logic [DATA_W-1:0]      exp_data,
    input  logic [2**ADDR_W-1:0]   chk_mask,
    input  logic [DATA_W-1:0]      ir,
    input  logic [DATA_W-1:0]      operand,
    output logic                   busy,
    output logic                   done,
    output logic                   halted,
    output logic                   timeout,
    output logic                   pass,
    output logic                   err_pulse,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       write_cnt,
    output logic [ERR_W-1:0]       error_cnt,
    output logic [ADDR_W-1:0]      first_err_addr,
    output logic [DATA_W-1:0]      first_err_data,
    output logic [DATA_W-1:0]      first_err_exp
);

    localparam int                SET_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MAX_LAST = CNT_W'(MAX_CYCLES - 1);

    generate
        if (MAX_CYCLES < 2) begin : g_bad_max
            $error("io_run_monitor: MAX_CYCLES must be >= 2");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("io_run_monitor: SETTLE_CYCLES must be >= 1");
        end
        if (CNT_W < 63) begin : g_cnt_range
            if (64'(MAX_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cnt
                $error("io_run_monitor: MAX_CYCLES must be < 2**CNT_W");
            end
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp;
    } err_rec_t;

    state_t           state;
    logic [SET_W-1:0] settle_cnt;
    err_rec_t         first_err;

    logic checked, mismatch, halt_hit, wd_hit;

    assign checked  = io_we & io_oe & chk_mask[io_addr];
    assign mismatch = checked & (io_data != exp_data);
    assign halt_hit = (ir == HALT_OPCODE) && (operand == HALT_OPERAND);
    assign wd_hit   = (cycle_cnt == MAX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            cycle_cnt  <= '0;
            write_cnt  <= '0;
            error_cnt  <= '0;
            first_err  <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        cycle_cnt  <= '0;
                        write_cnt  <= '0;
                        error_cnt  <= '0;
                        first_err  <= '0;
                        halted     <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                // Bus is ignored here so post-reset PC/IR garbage never counts.
                SETTLE: begin
                    if (settle_cnt == SET_LAST) state <= RUN;
                    else                        settle_cnt <= settle_cnt + SET_W'(1);
                end
                RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (checked) write_cnt <= write_cnt + CNT_W'(1);
                    if (mismatch) begin
                        err_pulse <= 1'b1;
                        if (error_cnt != '1) error_cnt <= error_cnt + ERR_W'(1);
                        if (error_cnt == '0) first_err <= '{addr: io_addr, data: io_data, exp: exp_data};
                    end
                    // Halt takes priority over a coincident watchdog expiry.
                    if (halt_hit) begin
                        state  <= DONE;
                        halted <= 1'b1;
                    end else if (wd_hit) begin
                        state   <= DONE;
                        timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy           = (state == SETTLE) || (state == RUN);
    assign done           = (state == DONE);
    assign pass           = done & halted & (error_cnt == '0);
    assign first_err_addr = first_err.addr;
    assign first_err_data = first_err.data;
    assign first_err_exp  = first_err.exp;

endmodule

// File: tb/tb_io_run_monitor.sv
// Directed and randomized bench for io_run_monitor; expected results come from a per-run
// reference model that scans the RUN-cycle stimulus table.
module tb_io_run_monitor;

    localparam int MAXC = 16;
    localparam int SETC = 2;
    localparam int ERRW = 2;

    logic        clk = 1'b0;
    logic        reset, start, io_we, io_oe;
    logic [3:0]  io_addr;
    logic [7:0]  io_data, exp_data, ir, operand;
    logic [15:0] chk_mask;
    logic        busy, done, halted, timeout, pass, err_pulse;
    logic [31:0] cycle_cnt, write_cnt;
    logic [ERRW-1:0] error_cnt;
    logic [3:0]  first_err_addr;
    logic [7:0]  first_err_data, first_err_exp;

    io_run_monitor #(
        .DATA_W(8), .ADDR_W(4), .MAX_CYCLES(MAXC), .SETTLE_CYCLES(SETC),
        .CNT_W(32), .ERR_W(ERRW), .HALT_OPCODE(8'h20), .HALT_OPERAND(8'hFE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .io_we(io_we), .io_oe(io_oe),
        .io_addr(io_addr), .io_data(io_data), .exp_data(exp_data), .chk_mask(chk_mask),
        .ir(ir), .operand(operand), .busy(busy), .done(done), .halted(halted),
        .timeout(timeout), .pass(pass), .err_pulse(err_pulse), .cycle_cnt(cycle_cnt),
        .write_cnt(write_cnt), .error_cnt(error_cnt), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .first_err_exp(first_err_exp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Stimulus table indexed by RUN cycle number (1-based).
    logic       s_we [1:MAXC];
    logic       s_oe [1:MAXC];
    logic       s_st [1:MAXC];
    logic [3:0] s_addr [1:MAXC];
    logic [7:0] s_data [1:MAXC];
    logic [7:0] s_exp [1:MAXC];
    logic [7:0] s_ir [1:MAXC];
    logic [7:0] s_opd [1:MAXC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start = 1'b0; io_we = 1'b0; io_oe = 1'b0; io_addr = '0;
        io_data = '0; exp_data = '0; ir = '0; operand = '0;
    endtask

    task automatic drive_garbage();
        start = 1'b1; io_we = 1'b1; io_oe = 1'b1; io_addr = '0;
        io_data = 8'h3C; exp_data = 8'hC3; ir = 8'h20; operand = 8'hFE;
    endtask

    task automatic drive(input int k);
        start = s_st[k]; io_we = s_we[k]; io_oe = s_oe[k]; io_addr = s_addr[k];
        io_data = s_data[k]; exp_data = s_exp[k]; ir = s_ir[k]; operand = s_opd[k];
    endtask

    task automatic clear_stim();
        for (int k = 1; k <= MAXC; k++) begin
            s_we[k] = 0; s_oe[k] = 0; s_st[k] = 0; s_addr[k] = 0;
            s_data[k] = 0; s_exp[k] = 0; s_ir[k] = 0; s_opd[k] = 0;
        end
    endtask

    task automatic set_wr(input int k, input logic [3:0] a, input logic [7:0] d, input logic [7:0] e);
        s_we[k] = 1; s_oe[k] = 1; s_addr[k] = a; s_data[k] = d; s_exp[k] = e;
    endtask

    task automatic set_halt(input int k);
        s_ir[k] = 8'h20; s_opd[k] = 8'hFE;
    endtask

    task automatic rand_stim();
        int h;
        for (int k = 1; k <= MAXC; k++) begin
            s_we[k]   = 1'($urandom_range(0, 1));
            s_oe[k]   = ($urandom_range(0, 3) != 0);
            s_st[k]   = 1'b0;
            s_addr[k] = 4'($urandom_range(0, 15));
            s_exp[k]  = 8'($urandom);
            s_data[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : s_exp[k];
            s_ir[k]   = 8'($urandom);
            s_opd[k]  = 8'($urandom);
        end
        h = $urandom_range(1, 20);
        if (h <= MAXC) set_halt(h);
    endtask

    // Run one start..DONE sequence from the stimulus table and compare with the model.
    task automatic run_check(input string nm);
        int e_end, e_wr, e_err, e_sat;
        logic e_halt, e_to, fin;
        logic [3:0] e_fa;
        logic [7:0] e_fd, e_fe;
        logic e_mm [1:MAXC];
        e_end = MAXC; e_halt = 0; e_to = 1; fin = 0;
        e_wr = 0; e_err = 0; e_fa = 0; e_fd = 0; e_fe = 0;
        for (int k = 1; k <= MAXC; k++) begin
            e_mm[k] = 0;
            if (!fin) begin
                if (s_we[k] && s_oe[k] && chk_mask[s_addr[k]]) begin
                    e_wr++;
                    if (s_data[k] != s_exp[k]) begin
                        e_mm[k] = 1;
                        if (e_err == 0) begin
                            e_fa = s_addr[k]; e_fd = s_data[k]; e_fe = s_exp[k];
                        end
                        e_err++;
                    end
                end
                if (s_ir[k] == 8'h20 && s_opd[k] == 8'hFE) begin
                    e_end = k; e_halt = 1; e_to = 0; fin = 1;
                end
            end
        end
        e_sat = (e_err > (2**ERRW - 1)) ? (2**ERRW - 1) : e_err;

        drive_idle();
        start = 1'b1;
        step();
        chk({nm, "/clr_cycle"}, cycle_cnt, 0);
        chk({nm, "/clr_write"}, write_cnt, 0);
        chk({nm, "/clr_error"}, error_cnt, 0);
        chk({nm, "/clr_flags"}, {halted, timeout, done, busy}, 4'b0001);
        for (int s = 0; s < SETC; s++) begin
            drive_garbage();
            step();
            chk({nm, "/settle_busy"}, busy, 1);
            chk({nm, "/settle_cycle"}, cycle_cnt, 0);
        end
        for (int k = 1; k <= e_end; k++) begin
            drive(k);
            step();
            chk({nm, "/cycle_cnt"}, cycle_cnt, k);
            chk({nm, "/err_pulse"}, err_pulse, e_mm[k]);
            chk({nm, "/done"}, done, (k == e_end));
        end
        drive_idle();
        chk({nm, "/halted"}, halted, e_halt);
        chk({nm, "/timeout"}, timeout, e_to);
        chk({nm, "/pass"}, pass, (e_halt && e_err == 0));
        chk({nm, "/write_cnt"}, write_cnt, e_wr);
        chk({nm, "/error_cnt"}, error_cnt, e_sat);
        chk({nm, "/first_err"}, {first_err_addr, first_err_data, first_err_exp}, {e_fa, e_fd, e_fe});
        drive_garbage();
        start = 1'b0;
        step();
        chk({nm, "/frozen_done"}, {done, busy, err_pulse}, 3'b100);
        chk({nm, "/frozen_cycle"}, cycle_cnt, e_end);
        chk({nm, "/frozen_write"}, write_cnt, e_wr);
        chk({nm, "/frozen_error"}, error_cnt, e_sat);
        drive_idle();
    endtask

    initial begin
        reset = 1'b1;
        chk_mask = 16'hFFFF;
        drive_idle();
        step();
        step();
        chk("reset/flags", {busy, done, halted, timeout, pass, err_pulse}, 6'b0);
        chk("reset/counts", {cycle_cnt, write_cnt, 30'(error_cnt)}, 94'b0);
        chk("reset/first_err", {first_err_addr, first_err_data, first_err_exp}, 20'b0);
        reset = 1'b0;
        step();
        chk("idle/no_start", {busy, done}, 2'b00);

        // Clean halt at RUN cycle 10 after three matching writes.
        clear_stim();
        for (int k = 1; k <= MAXC; k++) s_exp[k] = 8'h05;
        set_wr(2, 4'h5, 8'h05, 8'h05);
        set_wr(4, 4'h5, 8'h05, 8'h05);
        set_wr(6, 4'h5, 8'h05, 8'h05);
        set_halt(10);
        run_check("clean");
        chk("clean/spec_values", {pass, halted, 32'(write_cnt), 32'(cycle_cnt)}, {1'b1, 1'b1, 32'd3, 32'd10});

        // Mismatch capture keeps the first error only.
        clear_stim();
        set_wr(3, 4'h3, 8'hAA, 8'h55);
        set_wr(5, 4'h1, 8'h00, 8'h01);
        set_halt(8);
        run_check("mismatch");
        chk("mismatch/spec_first", {first_err_addr, first_err_data, first_err_exp, 2'(error_cnt)},
            {4'h3, 8'hAA, 8'h55, 2'd2});

        // Mask and strobes filter writes.
        chk_mask = 16'h0001;
        clear_stim();
        set_wr(2, 4'h2, 8'h11, 8'h22);
        set_wr(3, 4'h0, 8'h11, 8'h22); s_oe[3] = 0;
        set_wr(4, 4'h0, 8'h11, 8'h22); s_we[4] = 0;
        set_halt(6);
        run_check("mask");
        chk("mask/spec", {pass, 32'(write_cnt)}, {1'b1, 32'd0});
        chk_mask = 16'hFFFF;

        // Watchdog with no halt, then halt landing on the final cycle.
        clear_stim();
        run_check("timeout");
        chk("timeout/spec", {timeout, halted, pass, 32'(cycle_cnt)}, {3'b100, 32'd16});
        set_halt(MAXC);
        run_check("halt_last");
        chk("halt_last/spec", {timeout, halted}, 2'b01);

        // Error counter saturates.
        clear_stim();
        for (int k = 1; k <= 5; k++) set_wr(k, 4'(k), 8'(k), 8'hF0);
        set_halt(7);
        run_check("saturate");
        chk("saturate/spec", error_cnt, 2'd3);

        // Start pulses while busy are ignored; restart from DONE reproduces results.
        rand_stim();
        clear_stim();
        set_wr(2, 4'h7, 8'h12, 8'h34);
        s_st[3] = 1; s_st[9] = 1;
        set_halt(12);
        run_check("start_busy");
        run_check("rerun");

        // Reset in the middle of a run.
        drive_idle();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int s = 0; s < SETC; s++) step();
        for (int k = 0; k < 3; k++) begin
            io_we = 1; io_oe = 1; io_addr = 4'h9; io_data = 8'h01; exp_data = 8'h02;
            step();
        end
        chk("midreset/pre", error_cnt, 2'd3);
        drive_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset/flags", {busy, done, halted, timeout, pass, err_pulse}, 6'b0);
        chk("midreset/counts", {cycle_cnt, write_cnt, 30'(error_cnt)}, 94'b0);
        chk("midreset/first_err", {first_err_addr, first_err_data, first_err_exp}, 20'b0);
        step();
        chk("midreset/idle", {busy, done}, 2'b00);

        // Randomized runs.
        for (int r = 0; r < 30; r++) begin
            chk_mask = 16'($urandom);
            rand_stim();
            run_check($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_run_monitor.md
Name: io_run_monitor

Overview:
Synthesizable, parametrised successor to the simulation-only I/O-write checker and halt watchdog around the `computer` top level. It snoops the CPU I/O bus and compares every enabled I/O write against a golden value supplied by the caller. It detects the "BRA *" halt idiom, enforces a cycle watchdog and reports pass/fail, so on-board and bench runs share one checker.

Parameters:
DATA_W, 8, width of io_data, exp_data, ir and operand
ADDR_W, 4, width of io_addr; the check mask has 2**ADDR_W bits
MAX_CYCLES, 2000, RUN-state cycles allowed before timeout (must be >= 2)
SETTLE_CYCLES, 2, cycles waited after start before checking begins (must be >= 1)
CNT_W, 32, width of cycle_cnt and write_cnt
ERR_W, 16, width of error_cnt (saturating)
HALT_OPCODE, 8'h20, IR value of the halt branch
HALT_OPERAND, 8'hFE, operand byte completing the halt pattern

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
io_we  in  1  CPU I/O write strobe
io_oe  in  1  CPU I/O output enable
io_addr  in  ADDR_W  I/O port address
io_data  in  DATA_W  value driven on the I/O bus
exp_data  in  DATA_W  golden expected value (normally A register)
chk_mask  in  2**ADDR_W  per-address check enable, bit n = port n
ir  in  DATA_W  CPU instruction register
operand  in  DATA_W  byte at PC+1
busy  out  1  high in SETTLE or RUN
done  out  1  high in DONE
halted  out  1  run ended on halt pattern
timeout  out  1  run ended on watchdog
pass  out  1  done & halted & (error_cnt==0)
err_pulse  out  1  one-cycle pulse, registered, cycle after a mismatch
cycle_cnt  out  CNT_W  RUN cycles elapsed
write_cnt  out  CNT_W  checked writes seen
error_cnt  out  ERR_W  mismatches, saturating at all-ones
first_err_addr  out  ADDR_W  io_addr of first mismatch
first_err_data  out  DATA_W  io_data of first mismatch
first_err_exp  out  DATA_W  exp_data of first mismatch

Behaviour:
- Reset: state IDLE; all outputs and counters 0; first_err_* 0.
- States are IDLE, SETTLE, RUN and DONE.
- IDLE→SETTLE on start. Entering SETTLE clears cycle_cnt, write_cnt, error_cnt, first_err_*, halted and timeout.
- SETTLE lasts exactly SETTLE_CYCLES cycles, then goes to RUN. No checks occur in SETTLE; this masks the post-reset PC/IR garbage.
- RUN, each cycle:
  - cycle_cnt++.
  - Checked write = io_we & io_oe & chk_mask[io_addr]. On a checked write, write_cnt++ and compare io_data vs exp_data over the full width.
  - On mismatch: error_cnt++ (holds at all-ones); err_pulse=1 the next cycle. If error_cnt was 0, capture first_err_addr/data/exp.
- Halt: ir==HALT_OPCODE && operand==HALT_OPERAND sampled in RUN → DONE with halted=1. A write on the halt cycle is still checked and counted.
- Timeout: a RUN cycle in which cycle_cnt == MAX_CYCLES-1 (before increment) and no halt → DONE with timeout=1; final cycle_cnt == MAX_CYCLES.
- Halt and timeout on the same cycle: halt wins; timeout stays 0.
- DONE: counters and flags frozen; pass combinational from frozen state. start→SETTLE (restart, counters cleared).
- start while busy is ignored.
- reset mid-run → IDLE next edge, everything cleared; no done pulse.
- Counters are observable one cycle after the sampling edge; done rises the cycle after the halt/timeout edge.
- cycle_cnt and write_cnt wrap modulo 2**CNT_W. A parameter check (elaboration error) enforces MAX_CYCLES < 2**CNT_W.

Test Plan:
- Clean halt: start, 3 checked writes with io_data==exp_data==8'h05, then ir=8'h20/operand=8'hFE at RUN cycle 10 → done, halted=1, pass=1, write_cnt=3, error_cnt=0, cycle_cnt=10.
- Mismatch capture: writes at addr 4'h3 data 8'hAA exp 8'h55, then addr 4'h1 8'h00 exp 8'h01, then halt → error_cnt=2, first_err_addr=3, first_err_data=8'hAA, first_err_exp=8'h55, two err_pulse cycles, pass=0.
- Mask and strobes: chk_mask=16'h0001, mismatching writes at addr 2, plus addr 0 with io_oe=0 → write_cnt=0, error_cnt=0, halt→pass=1.
- Watchdog: MAX_CYCLES=16, no halt → done after 16 RUN cycles, timeout=1, halted=0, cycle_cnt=16, pass=0; halt pattern on cycle 16 itself → halted=1, timeout=0.
- Saturation with ERR_W=2: 5 mismatches → error_cnt=3 and held.
- Control edges: start during RUN ignored; reset asserted mid-RUN → all outputs 0 next cycle; start from DONE clears counters and reruns to identical results.
